// File: rtl/img_lut_swap_ctrl_if.sv
// Host/datapath-side signal bundle of the LUT double-buffer controller.
// The slave modport is the controller's view; master is the host/datapath view.
interface img_lut_swap_ctrl_if #(
  parameter int unsigned PX_WIDTH = 10
) ();
  logic                host_wr_i;
  logic [PX_WIDTH-1:0] host_addr_i;
  logic [PX_WIDTH-1:0] host_data_i;
  logic                fill_req_i;
  logic                commit_i;
  logic                frame_bnd_i;
  logic                lut_we_o;
  logic [PX_WIDTH:0]   lut_waddr_o;
  logic [PX_WIDTH-1:0] lut_wdata_o;
  logic                active_bank_o;
  logic                busy_o;
  logic                swap_pend_o;
  logic                swap_done_o;
  logic                err_o;

  modport slave (
    input  host_wr_i, host_addr_i, host_data_i, fill_req_i, commit_i, frame_bnd_i,
    output lut_we_o, lut_waddr_o, lut_wdata_o, active_bank_o, busy_o, swap_pend_o,
    output swap_done_o, err_o
  );

  modport master (
    output host_wr_i, host_addr_i, host_data_i, fill_req_i, commit_i, frame_bnd_i,
    input  lut_we_o, lut_waddr_o, lut_wdata_o, active_bank_o, busy_o, swap_pend_o,
    input  swap_done_o, err_o
  );
endinterface

// File: rtl/img_lut_swap_ctrl.sv
// Double-buffered pixel LUT controller: host writes and identity fills target the shadow
// bank; a committed swap takes effect only at a frame boundary.
module img_lut_swap_ctrl #(
  parameter int unsigned PX_WIDTH  = 10,
  parameter logic        INIT_BANK = 1'b0
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  img_lut_swap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StFill, StPend} state_e;

  state_e              state_q, state_d;
  logic [PX_WIDTH-1:0] cnt_q, cnt_d;
  logic                commit_q, commit_d;
  logic                active_q, active_d;
  logic                we_q, we_d;
  logic [PX_WIDTH:0]   waddr_q, waddr_d;
  logic [PX_WIDTH-1:0] wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                shadow;

  assign shadow = ~active_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_d = commit_q;
    active_d = active_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.fill_req_i) begin
          // Entry n=0 is issued straight from IDLE so writes start the next cycle.
          state_d  = StFill;
          commit_d = bus.commit_i;
          we_d     = 1'b1;
          waddr_d  = {shadow, {PX_WIDTH{1'b0}}};
          wdata_d  = '0;
          cnt_d    = PX_WIDTH'(1);
          err_d    = bus.host_wr_i;
        end else if (bus.commit_i) begin
          state_d = StPend;
          err_d   = bus.host_wr_i;
        end else if (bus.host_wr_i) begin
          we_d    = 1'b1;
          waddr_d = {shadow, bus.host_addr_i};
          wdata_d = bus.host_data_i;
        end
      end
      StFill: begin
        err_d = bus.host_wr_i | bus.fill_req_i;
        if (bus.commit_i) commit_d = 1'b1;
        // Counter wrapped to zero: the last entry is on the bus this cycle.
        if (cnt_q == '0) begin
          state_d = (commit_q || bus.commit_i) ? StPend : StIdle;
        end else begin
          we_d    = 1'b1;
          waddr_d = {shadow, cnt_q};
          wdata_d = cnt_q;
          cnt_d   = cnt_q + PX_WIDTH'(1);
        end
      end
      StPend: begin
        err_d = bus.host_wr_i | bus.fill_req_i;
        if (bus.frame_bnd_i) begin
          active_d = ~active_q;
          done_d   = 1'b1;
          commit_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      active_q <= INIT_BANK;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      active_q <= active_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.lut_we_o      = we_q;
  assign bus.lut_waddr_o   = waddr_q;
  assign bus.lut_wdata_o   = wdata_q;
  assign bus.active_bank_o = active_q;
  assign bus.busy_o        = (state_q != StIdle);
  assign bus.swap_pend_o   = (state_q == StPend);
  assign bus.swap_done_o   = done_q;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_img_lut_swap_ctrl.sv
// Bench for img_lut_swap_ctrl (PX_WIDTH=4): LUT writes are checked against a queue of
// expected {cycle, addr, data}; control outputs are checked inline per scenario.
module tb_img_lut_swap_ctrl;

  localparam int unsigned PW = 4;

  typedef struct packed {
    int            cyc;
    logic [PW:0]   addr;
    logic [PW-1:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   cyc_n;
  int   n_cmp;
  int   n_bad;
  logic exp_bank;
  wr_t  sb[$];

  img_lut_swap_ctrl_if #(.PX_WIDTH(PW)) bus ();

  img_lut_swap_ctrl #(.PX_WIDTH(PW), .INIT_BANK(1'b0)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_wr(input int c, input logic [PW:0] a, input logic [PW-1:0] d);
    wr_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Advance one cycle, clear strobes, and score any LUT write seen in the new cycle.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc_n++;
    bus.host_wr_i   = 1'b0;
    bus.fill_req_i  = 1'b0;
    bus.commit_i    = 1'b0;
    bus.frame_bnd_i = 1'b0;
    while (sb.size() > 0 && sb[0].cyc < cyc_n) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_write: got no write, required addr=%h data=%h at cycle %0d",
               e.addr, e.data, e.cyc);
    end
    if (bus.lut_we_o !== 1'b0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got we=%b addr=%h data=%h at cycle %0d, required none",
                 bus.lut_we_o, bus.lut_waddr_o, bus.lut_wdata_o, cyc_n);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc_n || bus.lut_waddr_o !== e.addr || bus.lut_wdata_o !== e.data) begin
          n_bad++;
          $display("FAIL lut_write: got addr=%h data=%h cycle %0d, required addr=%h data=%h cycle %0d",
                   bus.lut_waddr_o, bus.lut_wdata_o, cyc_n, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic push_fill(input int count);
    for (int n = 0; n < count; n++) push_wr(cyc_n + 1 + n, {~exp_bank, PW'(n)}, PW'(n));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.active_bank_o !== 1'b0 || bus.lut_we_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.err_o !== 1'b0 || bus.swap_pend_o !== 1'b0 || bus.swap_done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got bank=%b we=%b busy=%b err=%b pend=%b done=%b, required all 0",
               bus.active_bank_o, bus.lut_we_o, bus.busy_o, bus.err_o, bus.swap_pend_o,
               bus.swap_done_o);
    end
    rst_n = 1'b1;
    tick();
    exp_bank = 1'b0;
  endtask

  task automatic test_idle_write();
    bus.host_wr_i   = 1'b1;
    bus.host_addr_i = 4'd5;
    bus.host_data_i = 4'd9;
    push_wr(cyc_n + 1, 5'h15, 4'd9);
    tick();
    tick();
    n_cmp++;
    if (bus.lut_we_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_write_we_low: got %b required 0", bus.lut_we_o);
    end
  endtask

  task automatic test_fill();
    bus.fill_req_i = 1'b1;
    push_fill(16);
    tick();
    for (int i = 1; i <= 16; i++) begin
      n_cmp++;
      if (bus.busy_o !== 1'b1) begin
        n_bad++;
        $display("FAIL fill_busy t+%0d: got %b required 1", i, bus.busy_o);
      end
      tick();
    end
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.swap_pend_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_end: got busy=%b pend=%b required 0/0", bus.busy_o, bus.swap_pend_o);
    end
  endtask

  task automatic test_swap();
    bus.commit_i = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      n_cmp++;
      if (bus.swap_pend_o !== 1'b1 || bus.active_bank_o !== exp_bank) begin
        n_bad++;
        $display("FAIL swap_pend t+%0d: got pend=%b bank=%b required 1/%b", i,
                 bus.swap_pend_o, bus.active_bank_o, exp_bank);
      end
      if (i == 3) bus.frame_bnd_i = 1'b1;
      tick();
    end
    exp_bank = ~exp_bank;
    n_cmp++;
    if (bus.active_bank_o !== exp_bank || bus.swap_done_o !== 1'b1 || bus.swap_pend_o !== 1'b0) begin
      n_bad++;
      $display("FAIL swap_edge: got bank=%b done=%b pend=%b required %b/1/0",
               bus.active_bank_o, bus.swap_done_o, bus.swap_pend_o, exp_bank);
    end
    tick();
    n_cmp++;
    if (bus.swap_done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL swap_done_pulse: got %b required 0", bus.swap_done_o);
    end
    bus.host_wr_i   = 1'b1;
    bus.host_addr_i = 4'd2;
    bus.host_data_i = 4'd7;
    push_wr(cyc_n + 1, 5'h02, 4'd7);
    tick();
    tick();
  endtask

  task automatic test_pend_rules();
    bus.frame_bnd_i = 1'b1;
    tick();
    n_cmp++;
    if (bus.active_bank_o !== exp_bank || bus.swap_done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_frame_bnd: got bank=%b done=%b required %b/0",
               bus.active_bank_o, bus.swap_done_o, exp_bank);
    end
    bus.commit_i = 1'b1;
    tick();
    bus.commit_i = 1'b1;
    tick();
    n_cmp++;
    if (bus.err_o !== 1'b0 || bus.swap_pend_o !== 1'b1) begin
      n_bad++;
      $display("FAIL pend_commit_ignored: got err=%b pend=%b required 0/1",
               bus.err_o, bus.swap_pend_o);
    end
    bus.fill_req_i = 1'b1;
    tick();
    n_cmp++;
    if (bus.err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL pend_fill_err: got %b required 1", bus.err_o);
    end
    bus.host_wr_i   = 1'b1;
    bus.host_addr_i = 4'd3;
    bus.host_data_i = 4'd3;
    tick();
    n_cmp++;
    if (bus.err_o !== 1'b1 || bus.swap_pend_o !== 1'b1) begin
      n_bad++;
      $display("FAIL pend_wr_err: got err=%b pend=%b required 1/1", bus.err_o, bus.swap_pend_o);
    end
    bus.frame_bnd_i = 1'b1;
    tick();
    exp_bank = ~exp_bank;
    n_cmp++;
    if (bus.active_bank_o !== exp_bank || bus.swap_done_o !== 1'b1 || bus.err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL pend_swap: got bank=%b done=%b err=%b required %b/1/0",
               bus.active_bank_o, bus.swap_done_o, bus.err_o, exp_bank);
    end
    tick();
  endtask

  task automatic test_collision();
    bus.fill_req_i = 1'b1;
    bus.commit_i   = 1'b1;
    push_fill(16);
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin
        bus.host_wr_i   = 1'b1;
        bus.host_addr_i = 4'd1;
        bus.host_data_i = 4'd1;
      end
      if (i == 6 || i == 7) begin
        n_cmp++;
        if (bus.err_o !== (i == 6)) begin
          n_bad++;
          $display("FAIL collision_err t+%0d: got %b required %b", i, bus.err_o, (i == 6));
        end
      end
      tick();
    end
    n_cmp++;
    if (bus.swap_pend_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL collision_pend: got pend=%b busy=%b required 1/1",
               bus.swap_pend_o, bus.busy_o);
    end
    tick();
    bus.frame_bnd_i = 1'b1;
    tick();
    exp_bank = ~exp_bank;
    n_cmp++;
    if (bus.active_bank_o !== exp_bank || bus.swap_done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL collision_swap: got bank=%b done=%b busy=%b required %b/1/0",
               bus.active_bank_o, bus.swap_done_o, bus.busy_o, exp_bank);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.fill_req_i  = 1'b1;
    bus.commit_i    = 1'b1;
    bus.host_wr_i   = 1'b1;
    bus.host_addr_i = 4'd4;
    bus.host_data_i = 4'd4;
    push_fill(6);
    tick();
    n_cmp++;
    if (bus.err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_wr_coincide_err: got %b required 1", bus.err_o);
    end
    tick();
    bus.fill_req_i = 1'b1;
    tick();
    n_cmp++;
    if (bus.err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_in_fill_err: got %b required 1", bus.err_o);
    end
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    exp_bank = 1'b0;
    n_cmp++;
    if (bus.lut_we_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.active_bank_o !== exp_bank ||
        bus.swap_pend_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got we=%b busy=%b bank=%b pend=%b required 0/0/0/0",
               bus.lut_we_o, bus.busy_o, bus.active_bank_o, bus.swap_pend_o);
    end
    rst_n = 1'b1;
    tick();
    tick();
    bus.frame_bnd_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.active_bank_o !== exp_bank || bus.swap_done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_no_swap %0d: got bank=%b done=%b busy=%b required %b/0/0",
                 i, bus.active_bank_o, bus.swap_done_o, bus.busy_o, exp_bank);
      end
      tick();
    end
  endtask

  initial begin
    cyc_n           = 0;
    n_cmp           = 0;
    n_bad           = 0;
    exp_bank        = 1'b0;
    rst_n           = 1'b0;
    bus.host_wr_i   = 1'b0;
    bus.host_addr_i = '0;
    bus.host_data_i = '0;
    bus.fill_req_i  = 1'b0;
    bus.commit_i    = 1'b0;
    bus.frame_bnd_i = 1'b0;
    test_reset();
    test_idle_write();
    test_fill();
    test_swap();
    test_pend_rules();
    test_collision();
    test_reset_mid();
    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending writes required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
